hdmi_video_timing_gen: RTL and testbench

Pixel-clock-domain controller that sequences the HDMI TX datapath. It generates the raster timing (hsync, vsync, data enable) and a deterministic test pattern that feeds the RGB, sync and DE inputs of the HDMI TX top. It starts and stops only on frame boundaries, so the TMDS encoders never see a truncated frame.

---
 rtl/hdmi_video_timing_gen_if.sv | 27 ++
 rtl/hdmi_video_timing_gen.sv | 152 +++++++++++++++
 tb/tb_hdmi_video_timing_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hdmi_video_timing_gen_if.sv
// Bundles the run request and the raster/pattern outputs of the timing generator.
// master: the generator itself; slave: the HDMI TX datapath that consumes the raster.
interface hdmi_video_timing_gen_if #(
    parameter int CW = 12
);
    logic          i_en;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;
    logic [23:0]   o_rgb_data;
    logic [CW-1:0] o_hcnt;
    logic [CW-1:0] o_vcnt;
    logic          o_frame_start;
    logic          o_busy;

    modport master (
        input  i_en,
        output o_hsync, o_vsync, o_de, o_rgb_data,
        output o_hcnt, o_vcnt, o_frame_start, o_busy
    );

    modport slave (
        output i_en,
        input  o_hsync, o_vsync, o_de, o_rgb_data,
        input  o_hcnt, o_vcnt, o_frame_start, o_busy
    );
endinterface

// File: rtl/hdmi_video_timing_gen.sv
// HDMI raster timing and test-pattern generator, pixel-clock domain.
// Starts and stops only on frame boundaries so downstream encoders never see
// a truncated frame.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | counters held at 0, all outputs at their inactive values
//   RUN   | raster running, frames repeat back-to-back
//   DRAIN | run request dropped, finishing the current frame
//
// The next-state process computes the counters for the coming cycle and the
// output process decodes those same values, so every registered output lines
// up with the registered o_hcnt/o_vcnt it is shown with.
module hdmi_video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic                     i_pixclk,
    input  logic                     i_reset,
    hdmi_video_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] h_cnt, h_nxt;
    logic [CW-1:0] v_cnt, v_nxt;
    logic [7:0]    frame_cnt, frame_nxt;
    logic          last_pixel;

    logic          hsync_q, vsync_q, de_q, fs_q, busy_q;
    logic [23:0]   rgb_q;
    logic          hsync_d, vsync_d, de_d, fs_d, busy_d;
    logic [23:0]   rgb_d;
    logic          active_nxt;

    assign last_pixel = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // State, counters and aligned outputs; reset forces everything inactive at once.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            de_q      <= 1'b0;
            rgb_q     <= '0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            frame_cnt <= frame_nxt;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            rgb_q     <= rgb_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end

    // Next state plus raster/frame counter advance.
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        frame_nxt = frame_cnt;
        case (state)
            IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (bus.i_en) begin
                    state_nxt = RUN;
                end
            end
            RUN, DRAIN: begin
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_nxt = h_cnt + 1'b1;
                end
                if (last_pixel) begin
                    frame_nxt = frame_cnt + 8'd1;
                end
                // A dropped request only takes effect once the frame is complete.
                if (bus.i_en) begin
                    state_nxt = RUN;
                end else if (last_pixel) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            default: begin
                state_nxt = IDLE;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        endcase
    end

    // Decode sync, DE and pattern from the values the counters take next cycle.
    always_comb begin
        active_nxt = (state_nxt != IDLE);
        busy_d     = active_nxt;
        de_d       = active_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hsync_d    = (active_nxt && (h_nxt >= HS_START) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d    = (active_nxt && (v_nxt >= VS_START) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
        fs_d       = active_nxt && (h_nxt == '0) && (v_nxt == '0);
        rgb_d      = de_d ? {h_nxt[7:0], v_nxt[7:0], frame_nxt} : 24'h000000;
    end

    assign bus.o_hsync       = hsync_q;
    assign bus.o_vsync       = vsync_q;
    assign bus.o_de          = de_q;
    assign bus.o_rgb_data    = rgb_q;
    assign bus.o_hcnt        = h_cnt;
    assign bus.o_vcnt        = v_cnt;
    assign bus.o_frame_start = fs_q;
    assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench for hdmi_video_timing_gen using a small raster:
// H 8/2/3/2 (15 per line), V 4/1/2/1 (8 lines), hsync active-low, vsync active-high.
module tb_hdmi_video_timing_gen;

    localparam int CW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hdmi_video_timing_gen_if #(.CW(CW)) bus ();

    hdmi_video_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .HS_POL   (1'b0),
        .VS_POL   (1'b1),
        .CW       (CW)
    ) dut (
        .i_pixclk (clk),
        .i_reset  (rst),
        .bus      (bus)
    );

    typedef struct {
        int          adv;
        bit          en;
        int          h;
        int          v;
        bit          de;
        bit          hs;
        bit          vs;
        bit          fs;
        bit          busy;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[21];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input int adv, input bit en, input int h, input int v,
                                input bit de, input bit hs, input bit vs, input bit fs,
                                input bit busy, input logic [23:0] rgb);
        vec_t r;
        r.adv = adv; r.en = en; r.h = h; r.v = v; r.de = de; r.hs = hs;
        r.vs = vs; r.fs = fs; r.busy = busy; r.rgb = rgb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input int h, input int v, input bit de,
                             input bit hs, input bit vs, input bit fs, input bit busy,
                             input logic [23:0] rgb);
        check({tag, ".hcnt"}, 32'(bus.o_hcnt), 32'(h));
        check({tag, ".vcnt"}, 32'(bus.o_vcnt), 32'(v));
        check({tag, ".de"}, 32'(bus.o_de), 32'(de));
        check({tag, ".hsync"}, 32'(bus.o_hsync), 32'(hs));
        check({tag, ".vsync"}, 32'(bus.o_vsync), 32'(vs));
        check({tag, ".fstart"}, 32'(bus.o_frame_start), 32'(fs));
        check({tag, ".busy"}, 32'(bus.o_busy), 32'(busy));
        check({tag, ".rgb"}, 32'(bus.o_rgb_data), 32'(rgb));
    endtask

    initial begin
        int n;
        bit found;

        // Time t counts cycles from the first RUN cycle: h = t%15, v = (t/15)%8.
        //              adv en  h  v de hs vs fs bsy rgb
        vecs[0]  = mk(1,  1,  0, 0, 1, 1, 0, 1, 1, 24'h000000); // t=0
        vecs[1]  = mk(7,  1,  7, 0, 1, 1, 0, 0, 1, 24'h070000); // last active pixel
        vecs[2]  = mk(1,  1,  8, 0, 0, 1, 0, 0, 1, 24'h000000);
        vecs[3]  = mk(2,  1, 10, 0, 0, 0, 0, 0, 1, 24'h000000); // hsync start
        vecs[4]  = mk(2,  1, 12, 0, 0, 0, 0, 0, 1, 24'h000000); // hsync end
        vecs[5]  = mk(1,  1, 13, 0, 0, 1, 0, 0, 1, 24'h000000);
        vecs[6]  = mk(2,  1,  0, 1, 1, 1, 0, 0, 1, 24'h000100); // t=15
        vecs[7]  = mk(45, 1,  0, 4, 0, 1, 0, 0, 1, 24'h000000); // t=60
        vecs[8]  = mk(14, 1, 14, 4, 0, 1, 0, 0, 1, 24'h000000); // t=74
        vecs[9]  = mk(1,  1,  0, 5, 0, 1, 1, 0, 1, 24'h000000); // vsync start
        vecs[10] = mk(29, 1, 14, 6, 0, 1, 1, 0, 1, 24'h000000); // t=104
        vecs[11] = mk(1,  1,  0, 7, 0, 1, 0, 0, 1, 24'h000000); // vsync end
        vecs[12] = mk(14, 1, 14, 7, 0, 1, 0, 0, 1, 24'h000000); // t=119
        vecs[13] = mk(1,  1,  0, 0, 1, 1, 0, 1, 1, 24'h000001); // frame 1 wraps in RUN
        vecs[14] = mk(20, 1,  5, 1, 1, 1, 0, 0, 1, 24'h050101); // t=140, drop en here
        vecs[15] = mk(13, 0,  3, 2, 1, 1, 0, 0, 1, 24'h030201); // DRAIN pattern
        vecs[16] = mk(5,  0,  8, 2, 0, 1, 0, 0, 1, 24'h000000);
        vecs[17] = mk(81, 0, 14, 7, 0, 1, 0, 0, 1, 24'h000000); // t=239, last pixel
        vecs[18] = mk(1,  0,  0, 0, 0, 1, 0, 0, 0, 24'h000000); // back to IDLE
        vecs[19] = mk(10, 0,  0, 0, 0, 1, 0, 0, 0, 24'h000000);
        vecs[20] = mk(1,  1,  0, 0, 1, 1, 0, 1, 1, 24'h000002); // frame 2 start

        bus.i_en = 1'b0;
        rst      = 1'b1;
        step(3);
        check_out("in_reset", 0, 0, 0, 1, 0, 0, 0, 24'h0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check_out("idle", 0, 0, 0, 1, 0, 0, 0, 24'h0);
        end

        for (int i = 0; i < 21; i++) begin
            bus.i_en = vecs[i].en;
            step(vecs[i].adv);
            check_out($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].hs,
                      vecs[i].vs, vecs[i].fs, vecs[i].busy, vecs[i].rgb);
        end

        // Drop then restore the run request inside frame 2: no gap, busy never falls.
        bus.i_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("drain_busy", 32'(bus.o_busy), 32'd1);
        end
        check_out("drain_mid", 5, 1, 1, 1, 0, 0, 1, 24'h050102);
        bus.i_en = 1'b1;
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step(1);
            n++;
            check("rerun_busy", 32'(bus.o_busy), 32'd1);
            if (bus.o_frame_start) found = 1'b1;
        end
        check("rerun_gap", 32'(n), 32'd100);
        check_out("frame3_start", 0, 0, 1, 1, 0, 1, 1, 24'h000003);

        n = 0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step(1);
            n++;
            if (bus.o_frame_start) found = 1'b1;
        end
        check("fs_period", 32'(n), 32'd120);

        n = 0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            step(1);
            n++;
            if (bus.o_hcnt == '0) found = 1'b1;
        end
        check("line_len", 32'(n), 32'd15);

        // Mid-frame reset with the run request held high.
        step(21);
        check_out("pre_rst", 6, 2, 1, 1, 0, 0, 1, 24'h060204);
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0, 1, 0, 0, 0, 24'h0);
        step(3);
        check_out("rst_held", 0, 0, 0, 1, 0, 0, 0, 24'h0);
        rst = 1'b0;
        step(1);
        check_out("post_rst", 0, 0, 1, 1, 0, 1, 1, 24'h000000);
        step(33);
        check_out("post_rst_pat", 3, 2, 1, 1, 0, 0, 1, 24'h030200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
